// File: rtl/aer_stream_arbiter_pkg.sv
// Shared types and constants for the address-event stream arbiter.
// Packet layout, LSB first: polarity, timestamp, column (y), row (x).
package aer_stream_arbiter_pkg;

  localparam int DEF_ROWS  = 8;
  localparam int DEF_COLS  = 8;
  localparam int DEF_POL_W = 2;
  localparam int DEF_TS_W  = 16;
  localparam int DEF_DEPTH = 8;

  localparam int POL_ON_BIT  = 1;
  localparam int POL_OFF_BIT = 0;

  localparam int PKT_POL_OFF = 0;
  localparam int PKT_TS_OFF  = 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ROW_SEL = 2'd1,
    COL_SEL = 2'd2,
    EMIT    = 2'd3
  } state_t;

  function automatic int pkt_y_off(input int ts_w);
    return PKT_TS_OFF + ts_w;
  endfunction

  function automatic int pkt_x_off(input int ts_w, input int y_w);
    return pkt_y_off(ts_w) + y_w;
  endfunction

endpackage

// File: rtl/aer_stream_arbiter_rr_arbiter.sv
// Generic round-robin arbiter: combinational one-hot grant, search pointer
// moves to one past the winner when the caller consumes the grant.
module rr_arbiter
  import aer_stream_arbiter_pkg::*;
#(
  parameter int N  = 8,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic [N-1:0]  req_i,
  input  logic          advance_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o
);

  // ptr_q holds the first index to examine, i.e. last winner + 1.
  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW-1:0] k_idx;
  logic          found;
  int            k;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    k     = 0;
    k_idx = '0;
    for (int i = 0; i < N; i++) begin
      k = int'(ptr_q) + i;
      if (k >= N) k = k - N;
      k_idx = IW'(k);
      if (!found && req_i[k_idx]) begin
        found        = 1'b1;
        gnt_o[k_idx] = 1'b1;
        idx_o        = k_idx;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (advance_i) begin
      ptr_d = (idx_o == IW'(N - 1)) ? '0 : idx_o + IW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/aer_stream_arbiter.sv
// Row-then-column round-robin address-event arbiter feeding a packet FIFO
// drained through a valid/ready stream, with prescaled timestamp.
module aer_stream_arbiter
  import aer_stream_arbiter_pkg::*;
#(
  parameter int ROWS        = DEF_ROWS,
  parameter int COLS        = DEF_COLS,
  parameter int POL_W       = DEF_POL_W,
  parameter int TS_W        = DEF_TS_W,
  parameter int TS_PRESCALE = 1,
  parameter int DEPTH       = DEF_DEPTH,
  parameter int X_W         = $clog2(ROWS),
  parameter int Y_W         = $clog2(COLS),
  parameter int PKT_W       = X_W + Y_W + TS_W + 1
) (
  input  logic                                 clk_i,
  input  logic                                 reset_i,
  input  logic                                 enable_i,
  input  logic                                 burst_mode_i,
  input  logic [ROWS-1:0][COLS-1:0][POL_W-1:0] req_i,
  output logic [ROWS-1:0][COLS-1:0]            gnt_o,
  output logic [PKT_W-1:0]                     m_data_o,
  output logic                                 m_valid_o,
  input  logic                                 m_ready_i,
  output logic [$clog2(DEPTH):0]               fifo_level_o,
  output logic                                 ts_wrap_o,
  output logic [15:0]                          stall_cnt_o
);

  localparam int AW    = $clog2(DEPTH);
  localparam int LW    = AW + 1;
  localparam int PS_W  = (TS_PRESCALE > 1) ? $clog2(TS_PRESCALE) : 1;
  localparam int Y_OFF = pkt_y_off(TS_W);
  localparam int X_OFF = pkt_x_off(TS_W, Y_W);

  state_t           state_q, state_d;
  logic [X_W-1:0]   x_lat_q, x_lat_d;
  logic [Y_W-1:0]   y_lat_q, y_lat_d;
  logic             pol_q, pol_d;
  logic [TS_W-1:0]  ts_lat_q, ts_lat_d;

  logic [ROWS-1:0]  row_act, row_gnt;
  logic [COLS-1:0]  col_act, col_gnt, col_on, y_onehot;
  logic [X_W-1:0]   row_idx;
  logic [Y_W-1:0]   col_idx;
  logic             row_any, col_any, row_adv, col_adv;

  logic [PKT_W-1:0] mem_q [DEPTH];
  logic [LW-1:0]    wptr_q, rptr_q, level;
  logic             full, pop, push, push_ok, stall;
  logic [PKT_W-1:0] pkt;

  logic [PS_W-1:0]  ps_q;
  logic [TS_W-1:0]  ts_q;
  logic             tick, wrap_q;
  logic [15:0]      stall_q;

  for (genvar gi = 0; gi < ROWS; gi++) begin : g_row_act
    assign row_act[gi] = |req_i[gi];
  end

  for (genvar gi = 0; gi < COLS; gi++) begin : g_col_act
    assign col_act[gi] = |req_i[x_lat_q][gi];
    assign col_on[gi]  = req_i[x_lat_q][gi][POL_ON_BIT];
  end

  rr_arbiter #(.N(ROWS)) u_row_rr (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .req_i     (row_act),
    .advance_i (row_adv),
    .gnt_o     (row_gnt),
    .idx_o     (row_idx)
  );

  // The column pointer moves when the column is latched; EMIT always
  // completes, so this is equivalent to moving it on the acknowledge.
  rr_arbiter #(.N(COLS)) u_col_rr (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .req_i     (col_act),
    .advance_i (col_adv),
    .gnt_o     (col_gnt),
    .idx_o     (col_idx)
  );

  assign row_any  = |row_gnt;
  assign col_any  = |col_gnt;
  assign y_onehot = COLS'(1) << y_lat_q;

  assign level     = wptr_q - rptr_q;
  assign full      = (level == LW'(DEPTH));
  assign m_valid_o = (level != '0);
  assign pop       = m_valid_o && m_ready_i;
  assign push_ok   = !full || pop;
  assign push      = (state_q == EMIT) && push_ok;
  assign stall     = (state_q == EMIT) && !push_ok;

  always_comb begin
    state_d  = state_q;
    x_lat_d  = x_lat_q;
    y_lat_d  = y_lat_q;
    pol_d    = pol_q;
    ts_lat_d = ts_lat_q;
    row_adv  = 1'b0;
    col_adv  = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable_i && row_any) state_d = ROW_SEL;
      end
      ROW_SEL: begin
        if (!enable_i) begin
          state_d = IDLE;
        end else if (row_any) begin
          x_lat_d = row_idx;
          row_adv = 1'b1;
          state_d = COL_SEL;
        end else begin
          state_d = IDLE;
        end
      end
      COL_SEL: begin
        if (!enable_i) begin
          state_d = IDLE;
        end else if (!col_any) begin
          state_d = ROW_SEL;
        end else begin
          y_lat_d  = col_idx;
          pol_d    = |(col_gnt & col_on);
          ts_lat_d = ts_q;
          col_adv  = 1'b1;
          state_d  = EMIT;
        end
      end
      EMIT: begin
        if (push_ok) begin
          if (burst_mode_i && ((col_act & ~y_onehot) != '0)) state_d = COL_SEL;
          else if (enable_i && row_any)                      state_d = ROW_SEL;
          else                                               state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q  <= IDLE;
      x_lat_q  <= '0;
      y_lat_q  <= '0;
      pol_q    <= 1'b0;
      ts_lat_q <= '0;
    end else begin
      state_q  <= state_d;
      x_lat_q  <= x_lat_d;
      y_lat_q  <= y_lat_d;
      pol_q    <= pol_d;
      ts_lat_q <= ts_lat_d;
    end
  end

  for (genvar gi = 0; gi < ROWS; gi++) begin : g_gnt_row
    for (genvar gj = 0; gj < COLS; gj++) begin : g_gnt_col
      assign gnt_o[gi][gj] = push && (x_lat_q == X_W'(gi)) && (y_lat_q == Y_W'(gj));
    end
  end

  always_comb begin
    pkt                       = '0;
    pkt[X_OFF +: X_W]         = x_lat_q;
    pkt[Y_OFF +: Y_W]         = y_lat_q;
    pkt[PKT_TS_OFF +: TS_W]   = ts_lat_q;
    pkt[PKT_POL_OFF]          = pol_q;
  end

  // Storage carries no reset so it maps onto RAM; validity lives in the pointers.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wptr_q[AW-1:0]] <= pkt;
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + LW'(1);
      if (pop)  rptr_q <= rptr_q + LW'(1);
    end
  end

  assign m_data_o     = m_valid_o ? mem_q[rptr_q[AW-1:0]] : '0;
  assign fifo_level_o = level;

  assign tick = (ps_q == PS_W'(TS_PRESCALE - 1));

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      ps_q    <= '0;
      ts_q    <= '0;
      wrap_q  <= 1'b0;
      stall_q <= '0;
    end else begin
      ps_q   <= tick ? '0 : ps_q + PS_W'(1);
      wrap_q <= tick && (ts_q == '1);
      if (tick) ts_q <= ts_q + TS_W'(1);
      if (stall && (stall_q != 16'hFFFF)) stall_q <= stall_q + 16'd1;
    end
  end

  assign ts_wrap_o   = wrap_q;
  assign stall_cnt_o = stall_q;

endmodule

// File: doc/aer_stream_arbiter.md
Name: aer_stream_arbiter

Overview:
- Parametrised successor to the row/column address-event arbiter: ROWS x COLS pixel array, round-robin row-then-column arbitration.
- Each pixel grant is a one-cycle acknowledge pulse.
- Each granted event is packed as {x, y, timestamp, polarity} and pushed into an internal FIFO, which drains through a valid/ready stream port.
- Adds output buffering, backpressure stall, selectable single/row-burst scan mode, a prescaled timestamp with a wrap flag, and a stall counter.

Parameters:
- ROWS, 8, pixel rows (>=2).
- COLS, 8, pixel columns (>=2).
- POL_W, 2, request bits per pixel; bit[1] = ON, bit[0] = OFF.
- TS_W, 16, timestamp width.
- TS_PRESCALE, 1, clock cycles per timestamp tick (>=1).
- DEPTH, 8, FIFO entries (power of two, >=2).
- X_W, $clog2(ROWS), row address width.
- Y_W, $clog2(COLS), column address width.
- PKT_W, X_W+Y_W+TS_W+1, packet width.

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  asynchronous, active-low reset.
- enable_i  in  1  arbitration enable.
- burst_mode_i  in  1  0 = single event per row grant; 1 = drain all active columns of the granted row.
- req_i  in  [ROWS][COLS][POL_W]  pixel requests, held by the pixel until acknowledged.
- gnt_o  out  [ROWS][COLS]  one-hot, one-cycle pixel acknowledge.
- m_data_o  out  PKT_W  packet: {x[X_W], y[Y_W], ts[TS_W], pol}, MSB first.
- m_valid_o  out  1  FIFO head valid.
- m_ready_i  in  1  consumer ready.
- fifo_level_o  out  $clog2(DEPTH)+1  current occupancy.
- ts_wrap_o  out  1  one-cycle pulse when the timestamp wraps to 0.
- stall_cnt_o  out  16  count of cycles spent in EMIT with the FIFO full; saturating.

Behaviour:
- Reset (reset_i low, asynchronous) values:
  - FSM = IDLE; both arbiter pointers = index 0.
  - gnt_o = 0, m_valid_o = 0, m_data_o = 0, fifo_level_o = 0.
  - ts = 0, prescaler = 0, ts_wrap_o = 0, stall_cnt_o = 0.
  - Reset mid-operation discards all FIFO contents and any in-flight event; no gnt_o is issued.
- Input reduction:
  - row_act[r] = OR of all req_i[r] bits.
  - col_act[c] = OR of req_i[x_lat][c] bits (x_lat = latched row).
- Round-robin (shared by row and column):
  - Search starts at last_grant+1 and wraps modulo N.
  - The pointer updates only when a grant is consumed.
- FSM states: IDLE, ROW_SEL, COL_SEL, EMIT.
  - IDLE: enable_i && |row_act -> ROW_SEL; otherwise stay.
  - ROW_SEL: !enable_i -> IDLE. If |row_act: latch x_lat = RR winner, advance row pointer, -> COL_SEL. Else -> IDLE.
  - COL_SEL:
    - !enable_i -> IDLE.
    - If col_act == 0 (request withdrawn) -> ROW_SEL, no event.
    - Else latch y_lat = RR winner, pol = req_i[x_lat][y_lat][1], ts_lat = ts; -> EMIT.
  - EMIT, push allowed (level < DEPTH, or a pop occurs in the same cycle):
    - Write the packet and assert gnt_o[x_lat][y_lat] for exactly this cycle.
    - Advance the column pointer.
    - Next state: COL_SEL if burst_mode_i && (col_act & ~onehot(y_lat)) != 0; else ROW_SEL if enable_i && |row_act; else IDLE.
  - EMIT, push blocked: hold all latched values, no gnt_o, stall_cnt_o += 1 (saturate at 0xFFFF).
  - EMIT always completes. enable_i is ignored in EMIT; it takes effect in the next state.
- Throughput: 3 cycles per event in single mode; 2 cycles per event within a row in burst mode.
- Polarity: ON has priority when both bits are set. One event per grant; the acknowledge clears the whole pixel.
- FIFO:
  - Pop when m_valid_o && m_ready_i.
  - m_data_o is the head entry, combinationally valid from a registered read pointer.
  - Latency: first write to m_valid_o high is 1 cycle.
  - Simultaneous push and pop when full: both occur and the level is unchanged.
  - Pop when empty: ignored.
  - Pointers are X+1 bits wide to distinguish full from empty.
- Timestamp:
  - Prescaler counts 0..TS_PRESCALE-1; ts increments on terminal count.
  - ts wraps from 2^TS_W-1 to 0, with ts_wrap_o pulsing in the same cycle ts becomes 0.
  - ts and the prescaler run regardless of enable_i.

Decomposition:
- arbiter_pkg additions:
  - state_t enum (2-bit): IDLE=0, ROW_SEL=1, COL_SEL=2, EMIT=3.
  - Packet field offset localparams.
  - Default constants ROWS, COLS, POL_W, TS_W, DEPTH.
- One generic sub-module: rr_arbiter #(N).
  - Ports: clk_i, reset_i, req_i[N], advance_i, gnt_o[N] (one-hot, combinational), idx_o[$clog2(N)].
  - Instantiated twice: row and column.
- FIFO and timestamp logic are inline.

Test Plan:
1. Reset then idle:
   - Hold reset_i low with random req_i -> all outputs 0.
   - Release with req_i = 0 and enable_i = 1 -> FSM stays IDLE, m_valid_o stays 0.
2. Single event:
   - ROWS = COLS = 8, req_i[2][5] = 2'b10, enable_i = 1, TS_PRESCALE = 1.
   - gnt_o[2][5] pulses on cycle 3 after leaving IDLE.
   - m_data_o = {3'd2, 3'd5, ts_at_COL_SEL, 1'b1}.
3. Fairness:
   - Pixels (0,1), (0,6), (4,3) all active, single mode, each cleared on its gnt.
   - Grant order is (0,1), (4,3), (0,6): the row pointer rotates before the row is revisited.
4. Burst mode:
   - Row 3, columns 0, 2, 7 active, burst_mode_i = 1.
   - Three grants 2 cycles apart, order 0, 2, 7; one ROW_SEL only.
5. Backpressure:
   - DEPTH = 4, m_ready_i = 0, 6 pixels active.
   - Exactly 4 gnt_o pulses; fifo_level_o = 4; stall_cnt_o increments every cycle.
   - Raise m_ready_i for 1 cycle -> 5th grant in the same cycle as the pop; level stays 4.
6. Timestamp wrap and abort:
   - TS_W = 4, TS_PRESCALE = 2 -> ts_wrap_o pulses every 32 cycles.
   - Drop enable_i in COL_SEL -> next state IDLE, no gnt_o.
   - Drop enable_i in EMIT with space available -> the grant still issues.
